// File: rtl/ysyx_mem_arbiter.sv
// Shares one memory port between instruction fetch (IFU) and load/store (LSU).
// One access is in flight at a time; a watchdog turns hung accesses into error responses.
module ysyx_mem_arbiter #(
  parameter bit LSU_PRIO    = 1'b1,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rsp_valid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_rsp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_rsp_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_rsp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

  state_t           state_reg, state_next;
  logic [31:0]      addr_reg, wdata_reg, rdata_reg;
  logic             wen_reg, err_reg;
  logic [3:0]       wmask_reg;
  logic             owner_lsu_reg, last_lsu_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_inc;
  logic             grant_lsu, grant_ifu, accept, timeout_hit;

  // On a tie the LSU wins outright, or (round-robin) whenever the IFU had the last grant.
  assign grant_lsu     = lsu_req_valid && (!ifu_req_valid || LSU_PRIO || !last_lsu_reg);
  assign grant_ifu     = ifu_req_valid && !grant_lsu;
  assign ifu_req_ready = (state_reg == S_IDLE) && grant_ifu;
  assign lsu_req_ready = (state_reg == S_IDLE) && grant_lsu;
  assign accept        = ifu_req_ready || lsu_req_ready;

  assign cnt_inc     = cnt_reg + CNT_W'(1);
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_inc == TIMEOUT_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = S_ISSUE;
      S_ISSUE: begin
        if (timeout_hit)        state_next = S_RESP;
        else if (mem_req_ready) state_next = S_WAIT;
      end
      // A real response arriving on the timeout cycle takes precedence.
      S_WAIT:  if (mem_rsp_valid || timeout_hit) state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg      <= '0;
      wen_reg       <= 1'b0;
      wdata_reg     <= '0;
      wmask_reg     <= '0;
      owner_lsu_reg <= 1'b0;
      last_lsu_reg  <= 1'b0;
      cnt_reg       <= '0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            owner_lsu_reg <= grant_lsu;
            last_lsu_reg  <= grant_lsu;
            cnt_reg       <= '0;
            if (grant_lsu) begin
              addr_reg  <= lsu_addr;
              wen_reg   <= lsu_wen;
              wdata_reg <= lsu_wdata;
              wmask_reg <= lsu_wen ? lsu_wmask : 4'b0000;
            end else begin
              addr_reg  <= ifu_addr;
              wen_reg   <= 1'b0;
              wdata_reg <= '0;
              wmask_reg <= 4'b0000;
            end
          end
        end
        S_ISSUE, S_WAIT: begin
          cnt_reg <= cnt_inc;
          if (state_reg == S_WAIT && mem_rsp_valid) begin
            rdata_reg <= wen_reg ? '0 : mem_rdata;
            err_reg   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_reg <= '0;
            err_reg   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req_valid = (state_reg == S_ISSUE);
  assign mem_addr      = addr_reg;
  assign mem_wen       = wen_reg;
  assign mem_wdata     = wdata_reg;
  assign mem_wmask     = wmask_reg;
  assign ifu_rsp_valid = (state_reg == S_RESP) && !owner_lsu_reg;
  assign lsu_rsp_valid = (state_reg == S_RESP) && owner_lsu_reg;
  assign ifu_rdata     = rdata_reg;
  assign lsu_rdata     = rdata_reg;
  assign ifu_rsp_err   = err_reg;
  assign lsu_rsp_err   = err_reg;
  assign busy          = (state_reg != S_IDLE);

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// Randomized scoreboard bench: a fixed-priority arbiter against a timed memory model,
// plus a round-robin instance kept under constant contention.
module tb_ysyx_mem_arbiter;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  logic        rr_ifu_req_valid, rr_ifu_req_ready, rr_ifu_rsp_valid, rr_ifu_rsp_err;
  logic [31:0] rr_ifu_addr, rr_ifu_rdata;
  logic        rr_lsu_req_valid, rr_lsu_req_ready, rr_lsu_wen, rr_lsu_rsp_valid, rr_lsu_rsp_err;
  logic [31:0] rr_lsu_addr, rr_lsu_wdata, rr_lsu_rdata;
  logic [3:0]  rr_lsu_wmask;
  logic        rr_mem_req_valid, rr_mem_req_ready, rr_mem_wen, rr_mem_rsp_valid, rr_busy;
  logic [31:0] rr_mem_addr, rr_mem_wdata, rr_mem_rdata;
  logic [3:0]  rr_mem_wmask;

  ysyx_mem_arbiter #(.LSU_PRIO(1'b1), .TIMEOUT_CYC(TO), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .busy(busy)
  );

  ysyx_mem_arbiter #(.LSU_PRIO(1'b0), .TIMEOUT_CYC(TO), .CNT_W(8)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(rr_ifu_req_valid), .ifu_req_ready(rr_ifu_req_ready), .ifu_addr(rr_ifu_addr),
    .ifu_rsp_valid(rr_ifu_rsp_valid), .ifu_rdata(rr_ifu_rdata), .ifu_rsp_err(rr_ifu_rsp_err),
    .lsu_req_valid(rr_lsu_req_valid), .lsu_req_ready(rr_lsu_req_ready), .lsu_addr(rr_lsu_addr),
    .lsu_wen(rr_lsu_wen), .lsu_wdata(rr_lsu_wdata), .lsu_wmask(rr_lsu_wmask),
    .lsu_rsp_valid(rr_lsu_rsp_valid), .lsu_rdata(rr_lsu_rdata), .lsu_rsp_err(rr_lsu_rsp_err),
    .mem_req_valid(rr_mem_req_valid), .mem_req_ready(rr_mem_req_ready), .mem_addr(rr_mem_addr),
    .mem_wen(rr_mem_wen), .mem_wdata(rr_mem_wdata), .mem_wmask(rr_mem_wmask),
    .mem_rsp_valid(rr_mem_rsp_valid), .mem_rdata(rr_mem_rdata), .busy(rr_busy)
  );

  // One planned access: requester fields plus how the memory will behave for it.
  typedef struct {
    bit          is_lsu;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] mdata;
    bit          drop;
    int          rdly;
    int          rspd;
  } acc_t;

  acc_t exp_q[$];
  int   acc_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h t=%0t", name, act, want, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired or unexpected event t=%0t", name, $time);
  endtask

  function automatic acc_t mk(input bit l, input logic [31:0] a, input logic w, input logic [31:0] wd,
                              input logic [3:0] wm, input logic [31:0] md, input bit dr,
                              input int rd, input int rs);
    acc_t x;
    x.is_lsu = l; x.addr = a; x.wen = w; x.wdata = wd; x.wmask = wm;
    x.mdata = md; x.drop = dr; x.rdly = rd; x.rspd = rs;
    return x;
  endfunction

  function automatic acc_t rnd_acc(input bit l);
    acc_t x;
    x = mk(l, $urandom, l ? 1'($urandom_range(0, 1)) : 1'b0, $urandom, 4'($urandom), $urandom,
           ($urandom_range(0, 7) == 0), 0, 0);
    if (x.drop) x.rdly = $urandom_range(0, 9);
    else begin
      x.rdly = $urandom_range(0, 4);
      x.rspd = $urandom_range(0, 6 - x.rdly);
    end
    return x;
  endfunction

  // Reference rules: IFU accesses carry no write info, loads carry no mask, stores read back 0.
  function automatic logic [31:0] exp_wen(input acc_t x);   return {31'd0, x.is_lsu & x.wen}; endfunction
  function automatic logic [31:0] exp_wdata(input acc_t x); return x.is_lsu ? x.wdata : 32'd0; endfunction
  function automatic logic [31:0] exp_wmask(input acc_t x); return (x.is_lsu && x.wen) ? {28'd0, x.wmask} : 32'd0; endfunction
  function automatic logic [31:0] exp_rdata(input acc_t x);
    if (x.drop || (x.is_lsu && x.wen)) return 32'd0;
    return x.mdata;
  endfunction
  function automatic int exp_lat(input acc_t x);
    return x.drop ? TO + 1 : x.rdly + x.rspd + 3;
  endfunction

  // Response monitor and per-cycle grant rule for the fixed-priority instance.
  acc_t        mon_e;
  int          mon_a;
  logic        mon_own;
  logic [31:0] mon_rd;
  logic        mon_er;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("lsu_req_ready", 32'(lsu_req_ready), 32'(!busy && lsu_req_valid));
      chk("ifu_req_ready", 32'(ifu_req_ready), 32'(!busy && ifu_req_valid && !lsu_req_valid));
    end
    if (ifu_rsp_valid || lsu_rsp_valid) begin
      chk("rsp_both", 32'(ifu_rsp_valid & lsu_rsp_valid), 32'd0);
      if (exp_q.size() == 0) fail_now("unexpected_rsp");
      else begin
        mon_e   = exp_q.pop_front();
        mon_a   = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
        mon_own = lsu_rsp_valid;
        mon_rd  = mon_own ? lsu_rdata : ifu_rdata;
        mon_er  = mon_own ? lsu_rsp_err : ifu_rsp_err;
        chk("rsp_owner", 32'(mon_own), 32'(mon_e.is_lsu));
        chk("rsp_rdata", mon_rd, exp_rdata(mon_e));
        chk("rsp_err", 32'(mon_er), 32'(mon_e.drop));
        chk("rsp_latency", 32'(cyc - mon_a), 32'(exp_lat(mon_e)));
        $display("rsp %s addr=%h wen=%0d rdata=%h err=%0d lat=%0d", mon_own ? "lsu" : "ifu",
                 mon_e.addr, mon_e.wen, mon_rd, mon_er, cyc - mon_a);
      end
    end
  end

  // Memory model: follows the plan of the access at the head of the scoreboard.
  initial begin
    int   icnt, wcnt;
    bit   pending, have;
    acc_t e;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    icnt = 0; wcnt = 0; pending = 1'b0;
    forever begin
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0; mem_req_ready = 1'b0; mem_rdata = $urandom;
      have = (exp_q.size() != 0);
      if (have) e = exp_q[0];
      if (!busy) begin pending = 1'b0; icnt = 0; end
      if (mem_req_valid) begin
        if (!have) fail_now("unexpected_mem_req");
        else begin
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_wen", 32'(mem_wen), exp_wen(e));
          chk("mem_wdata", mem_wdata, exp_wdata(e));
          chk("mem_wmask", 32'(mem_wmask), exp_wmask(e));
          mem_req_ready = (icnt == e.rdly);
          if (mem_req_ready) begin pending = 1'b1; wcnt = 0; end
        end
        icnt++;
      end else if (pending && have && !e.drop) begin
        if (wcnt == e.rspd) begin mem_rsp_valid = 1'b1; mem_rdata = e.mdata; pending = 1'b0; end
        wcnt++;
      end
      // Stray strobes where the arbiter must ignore them.
      if (!pending && !mem_rsp_valid && (!busy || (mem_req_valid && !mem_req_ready)) &&
          $urandom_range(0, 3) == 0) mem_rsp_valid = 1'b1;
    end
  end

  // Round-robin instance: both requesters always valid, so grants must alternate from LSU.
  bit rr_next_lsu = 1'b1;
  bit rr_owner_lsu = 1'b0;
  initial begin
    rr_ifu_req_valid = 1'b1; rr_ifu_addr = 32'h8000_0100;
    rr_lsu_req_valid = 1'b1; rr_lsu_addr = 32'h8000_2000; rr_lsu_wen = 1'b0;
    rr_lsu_wdata = '0; rr_lsu_wmask = '0;
    rr_mem_req_ready = 1'b1; rr_mem_rsp_valid = 1'b1; rr_mem_rdata = 32'h1234_5678;
  end
  always @(negedge clk) begin
    if (!rst_n) rr_next_lsu = 1'b1;
    else begin
      if (rr_ifu_req_ready || rr_lsu_req_ready) begin
        chk("rr_grant_lsu", 32'(rr_lsu_req_ready), 32'(rr_next_lsu));
        chk("rr_grant_both", 32'(rr_ifu_req_ready & rr_lsu_req_ready), 32'd0);
        rr_owner_lsu = rr_lsu_req_ready;
        rr_next_lsu  = !rr_lsu_req_ready;
      end
      if (rr_ifu_rsp_valid || rr_lsu_rsp_valid)
        chk("rr_rsp_owner", 32'(rr_lsu_rsp_valid), 32'(rr_owner_lsu));
    end
  end

  task automatic run_round(input bit lv, input acc_t la, input bit iv, input acc_t ia);
    int guard;
    bit ldone, idone;
    if (lv) exp_q.push_back(la);
    if (iv) exp_q.push_back(ia);
    @(posedge clk); #1;
    lsu_req_valid = lv; lsu_addr = la.addr; lsu_wen = la.wen; lsu_wdata = la.wdata; lsu_wmask = la.wmask;
    ifu_req_valid = iv; ifu_addr = ia.addr;
    ldone = !lv; idone = !iv; guard = 0;
    while (!(ldone && idone) && guard < 200) begin
      @(negedge clk); guard++;
      if (lsu_req_valid && lsu_req_ready) begin ldone = 1'b1; acc_q.push_back(cyc); end
      if (ifu_req_valid && ifu_req_ready) begin idone = 1'b1; acc_q.push_back(cyc); end
      @(posedge clk); #1;
      if (ldone) begin
        lsu_req_valid = 1'b0; lsu_addr = $urandom; lsu_wen = 1'($urandom);
        lsu_wdata = $urandom; lsu_wmask = 4'($urandom);
      end
      if (idone) begin ifu_req_valid = 1'b0; ifu_addr = $urandom; end
    end
    if (!(ldone && idone)) begin
      fail_now("accept_wait");
      lsu_req_valid = 1'b0; ifu_req_valid = 1'b0;
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin @(negedge clk); guard++; end
    if (exp_q.size() != 0) begin
      fail_now("rsp_wait");
      exp_q.delete(); acc_q.delete();
    end
  endtask

  acc_t none;
  initial begin
    int   guard;
    acc_t r;
    rst_n = 1'b0;
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    none = mk(1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_ifu_rsp_valid", 32'(ifu_rsp_valid), 32'd0);
    chk("rst_lsu_rsp_valid", 32'(lsu_rsp_valid), 32'd0);
    chk("rst_ifu_req_ready", 32'(ifu_req_ready), 32'd0);
    chk("rst_lsu_req_ready", 32'(lsu_req_ready), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
    chk("rst_ifu_rdata", ifu_rdata, 32'd0);
    chk("rst_lsu_rdata", lsu_rdata, 32'd0);
    chk("rst_err", 32'(ifu_rsp_err | lsu_rsp_err), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed: minimum-latency fetch, store, backpressure, ties, timeouts, timeout boundary.
    run_round(1'b0, none, 1'b1, mk(1'b0, 32'h8000_0000, 1'b0, 32'd0, 4'd0, 32'h0000_0413, 1'b0, 0, 0));
    run_round(1'b1, mk(1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h5555_AAAA, 1'b0, 0, 1), 1'b0, none);
    run_round(1'b0, none, 1'b1, mk(1'b0, 32'h8000_0004, 1'b0, 32'd0, 4'd0, 32'hCAFE_0001, 1'b0, 5, 0));
    for (int k = 0; k < 3; k++) run_round(1'b1, rnd_acc(1'b1), 1'b1, rnd_acc(1'b0));
    run_round(1'b0, none, 1'b1, mk(1'b0, 32'h8000_0008, 1'b0, 32'd0, 4'd0, 32'h1111_2222, 1'b1, 0, 0));
    run_round(1'b1, mk(1'b1, 32'h8000_3000, 1'b0, 32'h0, 4'h3, 32'h3333_4444, 1'b1, 9, 0), 1'b0, none);
    run_round(1'b1, mk(1'b1, 32'h8000_3004, 1'b0, 32'h0, 4'h0, 32'h7777_8888, 1'b0, 2, 4), 1'b0, none);

    for (int k = 0; k < 150; k++) begin
      int sel;
      sel = $urandom_range(0, 2);
      run_round(sel != 0, rnd_acc(1'b1), sel != 1, rnd_acc(1'b0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Reset in the middle of an access waiting for memory.
    r = mk(1'b0, 32'h8000_0040, 1'b0, 32'd0, 4'd0, 32'h9999_0000, 1'b1, 0, 0);
    exp_q.push_back(r);
    @(posedge clk); #1;
    ifu_req_valid = 1'b1; ifu_addr = r.addr;
    guard = 0;
    while (!(busy && !mem_req_valid) && guard < 50) begin
      @(posedge clk); #1; guard++;
      ifu_req_valid = 1'b0;
    end
    if (!(busy && !mem_req_valid)) fail_now("reach_wait");
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_rsp_valid", 32'(ifu_rsp_valid | lsu_rsp_valid), 32'd0);
    exp_q.delete(); acc_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run_round(1'b0, none, 1'b1, mk(1'b0, 32'h8000_0000, 1'b0, 32'd0, 4'd0, 32'h0000_0413, 1'b0, 0, 0));
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
